// File: rtl/tag_flag_ram_nway.sv
// N-way set-associative tag/valid/dirty store with tree-PLRU victim selection and an invalidate-all sweep.
// Optional per-entry even parity is enabled by defining TAGRAM_PARITY_EN.
module tag_flag_ram_nway #(
  parameter int PABITS      = 36,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 4,
  parameter int WAYS        = 2,
  localparam int TAG_W      = PABITS - INDEX_BITS - OFFSET_BITS,
  localparam int WB         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] Index,
  input  logic [TAG_W-1:0]      Tag_Cmp,
  input  logic [TAG_W-1:0]      Tag_Set,
  input  logic                  Write,
  input  logic [WB-1:0]         WriteWay,
  input  logic                  Valid,
  input  logic                  Dirty,
  input  logic                  Touch,
  input  logic [WB-1:0]         TouchWay,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  MatchHit,
  output logic [WB-1:0]         MatchWay,
  output logic                  MatchDirty,
  output logic [WB-1:0]         VictimWay,
  output logic [TAG_W-1:0]      VictimTag,
  output logic                  VictimValid,
  output logic                  VictimDirty,
  output logic                  ParityErr
);
  localparam int SETS   = 2 ** INDEX_BITS;
  localparam int LEVELS = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int PW     = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int EW     = TAG_W + 2;
  localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(SETS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;

  // Entry layout: {valid, dirty, tag}
  logic [EW-1:0] ent_mem [WAYS][SETS];
  logic [PW-1:0] plru_mem [SETS];
  logic [EW-1:0] rd_ent_q [WAYS];
  logic [PW-1:0] rd_plru_q;
`ifdef TAGRAM_PARITY_EN
  logic          par_mem [WAYS][SETS];
  logic          rd_par_q [WAYS];
`endif

  logic          sweep, wr_en, plru_upd;
  logic [WB-1:0] upd_way;

  // PLRU tree nodes are heap-numbered from 1; each bit points toward the victim child.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WB-1:0] w);
    int node;
    node = 1;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      p[node-1] = ~w[l];
      node = node * 2 + (w[l] ? 1 : 0);
    end
    return p;
  endfunction

  function automatic logic [WB-1:0] plru_victim(input logic [PW-1:0] p);
    int node;
    node = 1;
    for (int l = 0; l < LEVELS; l++) node = node * 2 + (p[node-1] ? 1 : 0);
    return WB'(node - WAYS);
  endfunction

  assign sweep    = (state_q == SWEEP);
  assign Busy     = sweep;
  assign wr_en    = Write & ~sweep;
  assign plru_upd = ~sweep & ((Write & Valid) | Touch);
  assign upd_way  = (Write & Valid) ? WriteWay : TouchWay;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage arrays carry no reset; the sweep clears them set by set.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (sweep) begin
        ent_mem[w][cnt_q] <= '0;
`ifdef TAGRAM_PARITY_EN
        par_mem[w][cnt_q] <= 1'b0;
`endif
      end else if (wr_en && WriteWay == WB'(w)) begin
        ent_mem[w][Index] <= {Valid, Dirty, Tag_Set};
`ifdef TAGRAM_PARITY_EN
        par_mem[w][Index] <= ^{Valid, Dirty, Tag_Set};
`endif
      end
    end
    if (sweep) plru_mem[cnt_q] <= '0;
    else if (plru_upd) plru_mem[Index] <= plru_touch(plru_mem[Index], upd_way);
  end

  // Read-first: the registers capture contents as they were before this edge's write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_ent_q[w] <= '0;
`ifdef TAGRAM_PARITY_EN
        rd_par_q[w] <= 1'b0;
`endif
      end
      rd_plru_q <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        rd_ent_q[w] <= ent_mem[w][Index];
`ifdef TAGRAM_PARITY_EN
        rd_par_q[w] <= par_mem[w][Index];
`endif
      end
      rd_plru_q <= plru_mem[Index];
    end
  end

  logic [WAYS-1:0] perr, eff_v, hit;
  logic [WB-1:0]   vic;

  always_comb begin
    perr       = '0;
    eff_v      = '0;
    hit        = '0;
    MatchHit   = 1'b0;
    MatchWay   = '0;
    MatchDirty = 1'b0;
    vic        = plru_victim(rd_plru_q);
    for (int w = 0; w < WAYS; w++) begin
`ifdef TAGRAM_PARITY_EN
      perr[w] = rd_par_q[w] ^ (^rd_ent_q[w]);
`endif
      eff_v[w] = rd_ent_q[w][EW-1] & ~perr[w];
      hit[w]   = eff_v[w] && (rd_ent_q[w][TAG_W-1:0] == Tag_Cmp);
    end
    // Descending scans so the lowest-numbered way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit[w]) begin
        MatchHit   = ~sweep;
        MatchWay   = sweep ? '0 : WB'(w);
        MatchDirty = ~sweep & rd_ent_q[w][EW-2];
      end
      if (!eff_v[w]) vic = WB'(w);
    end
  end

  assign VictimWay   = vic;
  assign VictimTag   = rd_ent_q[vic][TAG_W-1:0];
  assign VictimValid = ~sweep & eff_v[vic];
  assign VictimDirty = ~sweep & rd_ent_q[vic][EW-2];
  assign ParityErr   = |perr;

endmodule

// File: tb/tb_tag_flag_ram_nway.sv
// Directed bench for tag_flag_ram_nway (WAYS=2, INDEX_BITS=6, TAG_W=26).
module tb_tag_flag_ram_nway;
  localparam int TAG_W = 26;
  localparam int WB    = 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       Index = '0;
  logic [TAG_W-1:0] Tag_Cmp = '0;
  logic [TAG_W-1:0] Tag_Set = '0;
  logic             Write = 1'b0;
  logic [WB-1:0]    WriteWay = '0;
  logic             Valid = 1'b0;
  logic             Dirty = 1'b0;
  logic             Touch = 1'b0;
  logic [WB-1:0]    TouchWay = '0;
  logic             Flush = 1'b0;
  logic             Busy, MatchHit, MatchDirty, VictimValid, VictimDirty, ParityErr;
  logic [WB-1:0]    MatchWay, VictimWay;
  logic [TAG_W-1:0] VictimTag;

  int checks = 0;
  int errors = 0;

  tag_flag_ram_nway dut (
    .clock(clock), .reset(reset), .Index(Index), .Tag_Cmp(Tag_Cmp), .Tag_Set(Tag_Set),
    .Write(Write), .WriteWay(WriteWay), .Valid(Valid), .Dirty(Dirty), .Touch(Touch),
    .TouchWay(TouchWay), .Flush(Flush), .Busy(Busy), .MatchHit(MatchHit),
    .MatchWay(MatchWay), .MatchDirty(MatchDirty), .VictimWay(VictimWay),
    .VictimTag(VictimTag), .VictimValid(VictimValid), .VictimDirty(VictimDirty),
    .ParityErr(ParityErr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [5:0] idx, input logic [WB-1:0] way,
                    input logic [TAG_W-1:0] tag, input logic v, input logic d);
    Index = idx; WriteWay = way; Tag_Set = tag; Valid = v; Dirty = d; Write = 1'b1;
    tick();
    Write = 1'b0;
  endtask

  task automatic touch(input logic [5:0] idx, input logic [WB-1:0] way);
    Index = idx; TouchWay = way; Touch = 1'b1;
    tick();
    Touch = 1'b0;
  endtask

  task automatic rd(input logic [5:0] idx, input logic [TAG_W-1:0] cmp);
    Index = idx; Tag_Cmp = cmp;
    tick();
  endtask

  // Counts cycles until Busy falls, bounded so a stuck sweep still reaches the summary.
  task automatic busy_len(output int n);
    n = 0;
    while (Busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    // Reset state and post-reset sweep length
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", Busy, 1);
    check("reset_hit", MatchHit, 0);
    check("reset_vtag", VictimTag, 0);
    reset = 1'b0;
    busy_len(n);
    check("reset_sweep_len", n, 64);
    rd(7, 0);
    check("empty_hit", MatchHit, 0);
    check("empty_vway", VictimWay, 0);
    check("empty_vvalid", VictimValid, 0);
    check("parity_off", ParityErr, 0);

    // Single valid dirty entry in way 1
    wr(5, 1, 26'h123, 1, 1);
    rd(5, 26'h123);
    check("s5_hit", MatchHit, 1);
    check("s5_way", MatchWay, 1);
    check("s5_dirty", MatchDirty, 1);
    Tag_Cmp = 26'h124;
    #1;
    check("s5_miss", MatchHit, 0);
    check("s5_miss_way", MatchWay, 0);
    check("s5_miss_dirty", MatchDirty, 0);
    check("s5_vway", VictimWay, 0);
    check("s5_vvalid", VictimValid, 0);

    // PLRU on a full set
    wr(9, 0, 26'hA, 1, 0);
    wr(9, 1, 26'hB, 1, 0);
    touch(9, 0);
    rd(9, 26'hB);
    check("s9_vway", VictimWay, 1);
    check("s9_vtag", VictimTag, 26'hB);
    check("s9_vvalid", VictimValid, 1);
    check("s9_vdirty", VictimDirty, 0);
    check("s9_hit_way", MatchWay, 1);
    touch(9, 1);
    rd(9, 26'hA);
    check("s9_vway2", VictimWay, 0);
    check("s9_vtag2", VictimTag, 26'hA);
    check("s9_hit_way0", MatchWay, 0);

    // Write and Touch together: WriteWay decides the PLRU
    wr(3, 1, 26'h44, 1, 0);
    rd(3, 26'h0);
    check("s3_pre_vway", VictimWay, 0);
    Index = 3; WriteWay = 0; Tag_Set = 26'h33; Valid = 1; Dirty = 0; Write = 1; TouchWay = 1; Touch = 1;
    tick();
    Write = 0; Touch = 0;
    rd(3, 26'h33);
    check("s3_vway", VictimWay, 1);
    check("s3_hit", MatchHit, 1);
    check("s3_hit_way", MatchWay, 0);

    // Flush sweep with a write and a second Flush mid-sweep
    wr(0, 0, 26'h100, 1, 1);
    wr(63, 1, 26'h63F, 1, 0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_busy", Busy, 1);
    Index = 63; Tag_Cmp = 26'h63F;
    n = 0;
    while (Busy && n < 200) begin
      if (n == 5) begin
        Index = 3; WriteWay = 0; Tag_Set = 26'h77; Valid = 1; Write = 1; Touch = 1; TouchWay = 1;
      end
      if (n == 10) Flush = 1'b1;
      tick();
      Write = 0; Touch = 0; Flush = 0;
      if (n == 0) begin
        check("sweep_hit_forced", MatchHit, 0);
        check("sweep_vvalid_forced", VictimValid, 0);
      end
      n++;
    end
    check("flush_sweep_len", n, 64);
    rd(0, 26'h100);
    check("s0_flushed", MatchHit, 0);
    rd(63, 26'h63F);
    check("s63_flushed", MatchHit, 0);
    rd(3, 26'h77);
    check("s3_write_ignored", MatchHit, 0);
    check("s3_vvalid", VictimValid, 0);

    // Reset mid-sweep clears outputs at once and restarts the sweep
    wr(50, 0, 26'h50A, 1, 0);
    wr(50, 1, 26'h50B, 1, 1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    Index = 50;
    repeat (30) tick();
    check("mid_vtag", VictimTag, 26'h50A);
    reset = 1'b1;
    #1;
    check("rst_mid_vtag", VictimTag, 0);
    check("rst_mid_busy", Busy, 1);
    tick();
    tick();
    reset = 1'b0;
    busy_len(n);
    check("rst_mid_sweep_len", n, 64);
    rd(50, 26'h50B);
    check("s50_cleared", MatchHit, 0);
    check("s50_vvalid", VictimValid, 0);
    check("parity_off_end", ParityErr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
